fetch_unit: RTL

Instruction fetch stage. It owns the PC, issues word requests to instruction memory, buffers returned words, and hands the instruction word plus its PC to the decode stage over a valid/ready handshake. It resolves redirects (JAL, JALR, taken branch) when the redirecting instruction is consumed, and it flushes both buffered and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/param_fetch.vh | 6 +
 rtl/param_pc_mux.vh | 7 +
 rtl/fetch_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared encodings and buffer entry type for the instruction fetch stage.
`include "param_pc_mux.vh"
`include "param_fetch.vh"
package fetch_unit_pkg;
  localparam int SEL_W = `SEL_PC_WIDTH;
  localparam logic [SEL_W-1:0] SEL_ADD4 = `SEL_PC_ADD4;
  localparam logic [SEL_W-1:0] SEL_JAL  = `SEL_PC_JAL;
  localparam logic [SEL_W-1:0] SEL_JALR = `SEL_PC_JALR;

  typedef enum logic [1:0] {
    ST_BOOT = `FETCH_ST_BOOT,
    ST_RUN  = `FETCH_ST_RUN,
    ST_HALT = `FETCH_ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } code_ent_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is presented combinationally.
// A push while full is accepted only together with a pop in the same cycle.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop, do_push;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(push_i && full_o && !do_pop));
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/param_fetch.vh
`ifndef PARAM_FETCH_VH
`define PARAM_FETCH_VH
`define FETCH_ST_BOOT 2'd0
`define FETCH_ST_RUN  2'd1
`define FETCH_ST_HALT 2'd2
`endif

// File: rtl/param_pc_mux.vh
`ifndef PARAM_PC_MUX_VH
`define PARAM_PC_MUX_VH
`define SEL_PC_WIDTH 2
`define SEL_PC_ADD4  2'd0
`define SEL_PC_JAL   2'd1
`define SEL_PC_JALR  2'd2
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests imem words under a credit limit,
// buffers them toward decode and resolves redirects when the redirecting word is consumed.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [31:0]      code,
  output logic [31:0]      code_pc,
  input  logic [SEL_W-1:0] pc_sel,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             br_taken,
  input  logic             halt,
  output logic             misalign_err
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          hold_q, hold_d;
  logic          misalign_q, misalign_d;

  code_ent_t     buf_in, buf_head;
  logic          buf_empty, buf_full, buf_push;
  logic [CW-1:0] buf_cnt;
  logic [31:0]   pcf_head;
  logic          pcf_empty, pcf_full;
  logic [CW-1:0] pcf_cnt;

  logic          accept, consume, redirect, credit_ok;
  logic [31:0]   target;
  logic [CW-1:0] inflight_nxt;

  // Credits count in-flight words (including ones to be discarded) plus buffered words.
  assign credit_ok      = ({1'b0, pcf_cnt} + {1'b0, buf_cnt}) < (CW+1)'(BUF_DEPTH);
  assign imem_req_valid = hold_q || (state_q == ST_RUN && credit_ok);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign consume        = code_valid && code_ready;
  assign code_valid     = !buf_empty;
  assign code           = buf_head.word;
  assign code_pc        = buf_head.pc;
  assign misalign_err   = misalign_q;
  assign inflight_nxt   = pcf_cnt + CW'(accept) - CW'(imem_rsp_valid);
  assign buf_push       = imem_rsp_valid && (discard_q == '0) && !redirect;
  assign buf_in         = '{pc: pcf_head, word: imem_rsp_data};

  always_comb begin
    redirect = 1'b0;
    target   = code_pc + imm;
    if (consume) begin
      case (pc_sel)
        SEL_JAL:  redirect = 1'b1;
        SEL_JALR: begin
          redirect = 1'b1;
          target   = (rs1_data + imm) & 32'hFFFF_FFFE;
        end
        SEL_ADD4: redirect = br_taken;
        default:  redirect = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    hold_d     = imem_req_valid && !imem_req_ready && !redirect;
    misalign_d = redirect && target[1];
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt) state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    if (accept) pc_d = pc_q + 32'd4;
    // Everything still in flight after this edge, including a same-cycle accept, is stale.
    if (redirect) begin
      pc_d      = word_align(target);
      discard_d = inflight_nxt;
    end else if (imem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      discard_q  <= '0;
      hold_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      assert (!(accept && pcf_full));
      assert (!(imem_rsp_valid && pcf_empty));
      assert (!(buf_push && buf_full && !consume));
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(.W(64), .DEPTH(BUF_DEPTH)) u_code_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (redirect),
    .push_i     (buf_push),
    .push_dat_i (buf_in),
    .pop_i      (consume),
    .pop_dat_o  (buf_head),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .count_o    (buf_cnt)
  );

  fetch_fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_pc_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .push_i     (accept),
    .push_dat_i (pc_q),
    .pop_i      (imem_rsp_valid),
    .pop_dat_o  (pcf_head),
    .full_o     (pcf_full),
    .empty_o    (pcf_empty),
    .count_o    (pcf_cnt)
  );
endmodule
